// File: rtl/_div_impl_pkg.sv
// rtl/_div_impl_pkg.sv - shared execute-stage types and constants for the iterative divider
package _div_impl_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_ITERS = XLEN;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_t;

    function automatic logic op_is_signed(input div_op_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(input div_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/_div_impl_if.sv
// rtl/_div_impl_if.sv - operand/result handshake bundle between issue, divider and writeback
interface _div_impl_if;
    import _div_impl_pkg::*;

    logic            in_valid;
    logic            in_ready;
    div_op_t         op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/_div_step.sv
// rtl/_div_step.sv - one combinational restoring step: shift in a dividend bit, compare, subtract
module _div_step
    import _div_impl_pkg::*;
(
    input  logic [XLEN-2:0] i_rem,
    input  logic            i_bit,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic            o_q
);

    logic [XLEN-1:0] w_t;
    logic            w_gt;
    logic            w_lt;

    // The partial remainder is below 2^(XLEN-1) before the final step, so its MSB never shifts out.
    assign w_t = {i_rem, i_bit};

    // MSB-first magnitude chain: the first differing bit decides.
    always_comb begin
        w_gt = 1'b0;
        w_lt = 1'b0;
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (!w_gt && !w_lt) begin
                w_gt = w_t[i] & ~i_div[i];
                w_lt = ~w_t[i] & i_div[i];
            end
        end
    end

    assign o_q   = ~w_lt;
    assign o_rem = w_lt ? w_t : (w_t - i_div);

endmodule

// File: rtl/_div_impl.sv
// rtl/_div_impl.sv - iterative restoring divider for RV32M DIV/DIVU/REM/REMU
module _div_impl
    import _div_impl_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    _div_impl_if.slave bus
);

    div_state_t      r_state, w_state_nxt;
    div_op_t         r_op;
    logic            r_sign_a, r_sign_b;
    logic [XLEN-1:0] r_quo, r_rem, r_div, r_result;
    logic [CNT_W-1:0] r_cnt;
    logic            r_out_valid;

    logic            w_signed_in, w_is_rem_in, w_b_zero, w_ovf, w_special;
    logic [XLEN-1:0] w_abs_a, w_abs_b, w_special_res;
    logic [XLEN-1:0] w_step_rem, w_quo_fix, w_rem_fix;
    logic            w_step_q;

    assign w_signed_in   = op_is_signed(bus.op);
    assign w_is_rem_in   = op_is_rem(bus.op);
    assign w_abs_a       = (w_signed_in && bus.a[XLEN-1]) ? -bus.a : bus.a;
    assign w_abs_b       = (w_signed_in && bus.b[XLEN-1]) ? -bus.b : bus.b;
    assign w_b_zero      = (bus.b == '0);
    assign w_ovf         = w_signed_in && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
    assign w_special     = w_b_zero || w_ovf;
    // Overflow quotient equals the dividend itself (0x80000000).
    assign w_special_res = w_b_zero ? (w_is_rem_in ? bus.a : '1)
                                    : (w_is_rem_in ? '0    : bus.a);

    _div_step u_step (
        .i_rem (r_rem[XLEN-2:0]),
        .i_bit (r_quo[XLEN-1]),
        .i_div (r_div),
        .o_rem (w_step_rem),
        .o_q   (w_step_q)
    );

    assign w_quo_fix = (r_sign_a ^ r_sign_b) ? -r_quo : r_quo;
    assign w_rem_fix = r_sign_a ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid) w_state_nxt = w_special ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == '0) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_DONE;
            S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.flush) w_state_nxt = S_IDLE;
    end

    always_comb begin
        bus.in_ready = (r_state == S_IDLE);
    end

    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= OP_DIV;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_op     <= bus.op;
                    r_sign_a <= w_signed_in & bus.a[XLEN-1];
                    r_sign_b <= w_signed_in & bus.b[XLEN-1];
                    r_quo    <= w_abs_a;
                    r_div    <= w_abs_b;
                    r_rem    <= '0;
                    r_cnt    <= CNT_W'(DIV_ITERS - 1);
                    if (w_special) begin
                        r_result    <= w_special_res;
                        r_out_valid <= 1'b1;
                    end
                end
                S_CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[XLEN-2:0], w_step_q};
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIX: begin
                    r_result    <= op_is_rem(r_op) ? w_rem_fix : w_quo_fix;
                    r_out_valid <= 1'b1;
                end
                S_DONE: if (bus.out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb__div_impl.sv
// tb/tb__div_impl.sv - directed and randomized scoreboard bench for the iterative divider
module tb__div_impl;
    import _div_impl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];

    _div_impl_if bus();

    _div_impl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_div(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: return (b == 0) ? a : a % b;
            OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            default: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
        endcase
    endfunction

    task automatic send(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("in_ready_before_accept", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic collect(input int exp_lat, input int hold);
        int n;
        logic [31:0] expv;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.out_valid) break;
        end
        check("latency", n, exp_lat);
        check("scoreboard_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
        expv = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("result", bus.result, expv);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
            check("hold_result", bus.result, expv);
            check("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_ack_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("post_ack_in_ready", {31'b0, bus.in_ready}, 32'd1);
    endtask

    task automatic run(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input int exp_lat, input int hold);
        exp_q.push_back(expv);
        send(op, a, b);
        collect(exp_lat, hold);
    endtask

    initial begin
        div_op_t rop;
        logic [31:0] ra, rb;
        logic seen;
        int lat;

        bus.in_valid = 1'b0;
        bus.op = OP_DIV;
        bus.a = '0;
        bus.b = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(OP_DIV,  32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
        run(OP_REM,  32'd7,        32'hFFFF_FFFE, 32'd1,         33, 0);
        run(OP_DIVU, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 33, 0);
        run(OP_REMU, 32'd100,      32'd7,         32'd2,         33, 5);
        run(OP_DIVU, 32'd5,        32'd0,         32'hFFFF_FFFF, 1,  0);
        run(OP_REM,  32'd5,        32'd0,         32'd5,         1,  0);
        run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1,  0);
        run(OP_REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, 0);

        // Flush mid-calculation.
        send(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("flush_no_out_valid", {31'b0, seen}, 32'd0);
        run(OP_DIV, 32'd20, 32'd3, 32'd6, 33, 0);

        // Asynchronous reset mid-calculation.
        send(OP_DIVU, 32'd999, 32'd10);
        repeat (14) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_mid_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_mid_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(OP_REMU, 32'd999, 32'd10, 32'd9, 33, 0);

        // Asynchronous reset while a result is held.
        send(OP_DIVU, 32'd5, 32'd0);
        #5;
        check("special_valid_before_rst", {31'b0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_done_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_done_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            rop = div_op_t'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            lat = ((rb == 0) || (op_is_signed(rop) && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 1 : 33;
            run(rop, ra, rb, ref_div(rop, ra, rb), lat, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
